// File: rtl/jump_control_sequencer_if.sv
// Handshake and strobe bundle between the jump/branch control sequencer and the datapath.
// The master side is the sequencer; the slave side is the datapath (or a bench).
interface jump_control_sequencer_if;
  logic        start;
  logic        halt_req;
  logic [4:0]  ir_opcode;
  logic        con_ff;

  logic        PC_out;
  logic        MDR_out;
  logic        Zlo_out;
  logic        R_out;
  logic        C_out;
  logic        MARin;
  logic        MDRin;
  logic        IRin;
  logic        PCin;
  logic        Yin;
  logic        Zlowin;
  logic        CONin;
  logic        Read;
  logic        IncPC;
  logic        Gra;
  logic        Grb;
  logic        BAout;
  logic        alu_add;
  logic [15:0] R_rd;
  logic        Rin;
  logic        busy;
  logic        done;
  logic        illegal;
  logic [2:0]  step;

  modport master (
    input  start, halt_req, ir_opcode, con_ff,
    output PC_out, MDR_out, Zlo_out, R_out, C_out,
    output MARin, MDRin, IRin, PCin, Yin, Zlowin, CONin,
    output Read, IncPC, Gra, Grb, BAout, alu_add,
    output R_rd, Rin, busy, done, illegal, step
  );

  modport slave (
    output start, halt_req, ir_opcode, con_ff,
    input  PC_out, MDR_out, Zlo_out, R_out, C_out,
    input  MARin, MDRin, IRin, PCin, Yin, Zlowin, CONin,
    input  Read, IncPC, Gra, Grb, BAout, alu_add,
    input  R_rd, Rin, busy, done, illegal, step
  );
endinterface

// File: rtl/jump_control_sequencer.sv
// Hardwired control sequencer for fetch plus jr/jal/br. Each T-step lasts STEP_CYCLES clocks;
// all strobes are registered and decoded from the next state so they are glitch-free.
module jump_control_sequencer #(
  parameter int unsigned STEP_CYCLES    = 2,
  parameter bit          RUN_CONTINUOUS = 1'b0,
  parameter logic [4:0]  OP_BR          = 5'b10010,
  parameter logic [4:0]  OP_JR          = 5'b10100,
  parameter logic [4:0]  OP_JAL         = 5'b10101,
  parameter int unsigned LINK_REG       = 15
) (
  input logic                        clk,
  input logic                        clr,
  jump_control_sequencer_if.master   bus
);

  typedef enum logic [3:0] {
    StIdle, StT0, StT1, StT2, StT3, StT4, StT5, StT6, StDone, StHalt
  } state_e;

  typedef enum logic [1:0] {ClsJr, ClsJal, ClsBr} cls_e;

  typedef struct packed {
    logic        PC_out;
    logic        MDR_out;
    logic        Zlo_out;
    logic        R_out;
    logic        C_out;
    logic        MARin;
    logic        MDRin;
    logic        IRin;
    logic        PCin;
    logic        Yin;
    logic        Zlowin;
    logic        CONin;
    logic        Read;
    logic        IncPC;
    logic        Gra;
    logic        Grb;
    logic        BAout;
    logic        alu_add;
    logic [15:0] R_rd;
    logic        Rin;
    logic        busy;
    logic        done;
    logic [2:0]  step;
  } ctrl_t;

  localparam logic [3:0]  LastCnt = 4'(STEP_CYCLES - 1);
  localparam logic [15:0] LinkSel = 16'(1) << LINK_REG;

  state_e     state_q, state_d;
  cls_e       cls_q, cls_d;
  logic [3:0] cnt_q, cnt_d;
  logic       halt_pend_q, halt_pend_d;
  logic       illegal_q, illegal_d;
  ctrl_t      ctrl_q, ctrl_d;
  logic       step_last;
  logic       in_step;

  assign step_last = (cnt_q == LastCnt);
  assign in_step   = (state_q inside {StT0, StT1, StT2, StT3, StT4, StT5, StT6});

  always_comb begin
    state_d     = state_q;
    cls_d       = cls_q;
    cnt_d       = cnt_q;
    illegal_d   = illegal_q;
    halt_pend_d = halt_pend_q | bus.halt_req;

    if (in_step) begin
      cnt_d = step_last ? 4'd0 : cnt_q + 4'd1;
    end

    case (state_q)
      StIdle: begin
        if (bus.start) begin
          state_d = StT0;
          cnt_d   = 4'd0;
        end
      end
      StT0: if (step_last) state_d = StT1;
      StT1: if (step_last) state_d = StT2;
      StT2: begin
        if (step_last) begin
          state_d = StT3;
          if (bus.ir_opcode == OP_JR) begin
            cls_d = ClsJr;
          end else if (bus.ir_opcode == OP_JAL) begin
            cls_d = ClsJal;
          end else if (bus.ir_opcode == OP_BR) begin
            cls_d = ClsBr;
          end else begin
            state_d   = StHalt;
            illegal_d = 1'b1;
          end
        end
      end
      StT3: if (step_last) state_d = (cls_q == ClsJr) ? StDone : StT4;
      StT4: if (step_last) state_d = (cls_q == ClsJal) ? StDone : StT5;
      StT5: if (step_last) state_d = bus.con_ff ? StT6 : StDone;
      StT6: if (step_last) state_d = StDone;
      StDone: begin
        // A halt request seen at any point during the instruction stops the loop here.
        if (RUN_CONTINUOUS && !bus.halt_req && !halt_pend_q) begin
          state_d = StT0;
          cnt_d   = 4'd0;
        end else begin
          state_d = StIdle;
        end
      end
      StHalt: state_d = StHalt;
      default: state_d = StIdle;
    endcase

    if (state_d == StIdle) begin
      halt_pend_d = 1'b0;
    end
  end

  // Strobes for the state being entered, so the registered outputs match the current step.
  always_comb begin
    ctrl_d = '0;
    case (state_d)
      StT0: begin
        ctrl_d.PC_out = 1'b1;
        ctrl_d.MARin  = 1'b1;
        ctrl_d.Zlowin = 1'b1;
        ctrl_d.IncPC  = (cnt_d == 4'd0);
        ctrl_d.busy   = 1'b1;
        ctrl_d.step   = 3'd0;
      end
      StT1: begin
        ctrl_d.Zlo_out = 1'b1;
        ctrl_d.PCin    = 1'b1;
        ctrl_d.Read    = 1'b1;
        ctrl_d.MDRin   = 1'b1;
        ctrl_d.busy    = 1'b1;
        ctrl_d.step    = 3'd1;
      end
      StT2: begin
        ctrl_d.MDR_out = 1'b1;
        ctrl_d.IRin    = 1'b1;
        ctrl_d.busy    = 1'b1;
        ctrl_d.step    = 3'd2;
      end
      StT3: begin
        ctrl_d.busy = 1'b1;
        ctrl_d.step = 3'd3;
        if (cls_d == ClsJal) begin
          ctrl_d.PC_out = 1'b1;
          ctrl_d.Rin    = 1'b1;
          ctrl_d.R_rd   = LinkSel;
        end else begin
          ctrl_d.Gra   = 1'b1;
          ctrl_d.R_out = 1'b1;
          ctrl_d.PCin  = (cls_d == ClsJr);
          ctrl_d.CONin = (cls_d == ClsBr);
        end
      end
      StT4: begin
        ctrl_d.busy = 1'b1;
        ctrl_d.step = 3'd4;
        if (cls_d == ClsJal) begin
          ctrl_d.Gra   = 1'b1;
          ctrl_d.R_out = 1'b1;
          ctrl_d.PCin  = 1'b1;
        end else begin
          ctrl_d.PC_out = 1'b1;
          ctrl_d.Yin    = 1'b1;
        end
      end
      StT5: begin
        ctrl_d.C_out   = 1'b1;
        ctrl_d.alu_add = 1'b1;
        ctrl_d.Zlowin  = 1'b1;
        ctrl_d.busy    = 1'b1;
        ctrl_d.step    = 3'd5;
      end
      StT6: begin
        ctrl_d.Zlo_out = 1'b1;
        ctrl_d.PCin    = 1'b1;
        ctrl_d.busy    = 1'b1;
        ctrl_d.step    = 3'd6;
      end
      StDone: ctrl_d.done = 1'b1;
      default: ctrl_d = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q     <= StIdle;
      cls_q       <= ClsJr;
      cnt_q       <= 4'd0;
      halt_pend_q <= 1'b0;
      illegal_q   <= 1'b0;
      ctrl_q      <= '0;
    end else begin
      state_q     <= state_d;
      cls_q       <= cls_d;
      cnt_q       <= cnt_d;
      halt_pend_q <= halt_pend_d;
      illegal_q   <= illegal_d;
      ctrl_q      <= ctrl_d;
    end
  end

  assign bus.PC_out  = ctrl_q.PC_out;
  assign bus.MDR_out = ctrl_q.MDR_out;
  assign bus.Zlo_out = ctrl_q.Zlo_out;
  assign bus.R_out   = ctrl_q.R_out;
  assign bus.C_out   = ctrl_q.C_out;
  assign bus.MARin   = ctrl_q.MARin;
  assign bus.MDRin   = ctrl_q.MDRin;
  assign bus.IRin    = ctrl_q.IRin;
  assign bus.PCin    = ctrl_q.PCin;
  assign bus.Yin     = ctrl_q.Yin;
  assign bus.Zlowin  = ctrl_q.Zlowin;
  assign bus.CONin   = ctrl_q.CONin;
  assign bus.Read    = ctrl_q.Read;
  assign bus.IncPC   = ctrl_q.IncPC;
  assign bus.Gra     = ctrl_q.Gra;
  assign bus.Grb     = ctrl_q.Grb;
  assign bus.BAout   = ctrl_q.BAout;
  assign bus.alu_add = ctrl_q.alu_add;
  assign bus.R_rd    = ctrl_q.R_rd;
  assign bus.Rin     = ctrl_q.Rin;
  assign bus.busy    = ctrl_q.busy;
  assign bus.done    = ctrl_q.done;
  assign bus.illegal = illegal_q;
  assign bus.step    = ctrl_q.step;

endmodule

// File: tb/tb_jump_control_sequencer.sv
// Scoreboard bench: each test queues per-cycle stimulus and expected outputs, then replays them.
// DUT a runs single-shot, DUT b free-running; both share the same inputs.
module tb_jump_control_sequencer;

  localparam logic [4:0] OpBr  = 5'b10010;
  localparam logic [4:0] OpJr  = 5'b10100;
  localparam logic [4:0] OpJal = 5'b10101;
  localparam int ClsJr  = 0;
  localparam int ClsJal = 1;
  localparam int ClsBr  = 2;

  typedef struct packed {
    logic        PC_out;
    logic        MDR_out;
    logic        Zlo_out;
    logic        R_out;
    logic        C_out;
    logic        MARin;
    logic        MDRin;
    logic        IRin;
    logic        PCin;
    logic        Yin;
    logic        Zlowin;
    logic        CONin;
    logic        Read;
    logic        IncPC;
    logic        Gra;
    logic        Grb;
    logic        BAout;
    logic        alu_add;
    logic [15:0] R_rd;
    logic        Rin;
    logic        busy;
    logic        done;
    logic        illegal;
    logic [2:0]  step;
  } obs_t;

  typedef struct packed {
    logic       start;
    logic       halt_req;
    logic       clr;
    logic       con_ff;
    logic [4:0] op;
    logic       chk;
  } stim_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       clr = 1'b1;
  logic       start = 1'b0;
  logic       halt_req = 1'b0;
  logic       con_ff = 1'b0;
  logic [4:0] ir_opcode = 5'b0;

  jump_control_sequencer_if ifa ();
  jump_control_sequencer_if ifb ();

  assign ifa.start     = start;
  assign ifa.halt_req  = halt_req;
  assign ifa.ir_opcode = ir_opcode;
  assign ifa.con_ff    = con_ff;
  assign ifb.start     = start;
  assign ifb.halt_req  = halt_req;
  assign ifb.ir_opcode = ir_opcode;
  assign ifb.con_ff    = con_ff;

  jump_control_sequencer #(.STEP_CYCLES(2), .RUN_CONTINUOUS(1'b0)) u_dut_a (
    .clk (clk),
    .clr (clr),
    .bus (ifa)
  );

  jump_control_sequencer #(.STEP_CYCLES(2), .RUN_CONTINUOUS(1'b1)) u_dut_b (
    .clk (clk),
    .clr (clr),
    .bus (ifb)
  );

  obs_t obs_a, obs_b;
  assign obs_a = {ifa.PC_out, ifa.MDR_out, ifa.Zlo_out, ifa.R_out, ifa.C_out, ifa.MARin,
                  ifa.MDRin, ifa.IRin, ifa.PCin, ifa.Yin, ifa.Zlowin, ifa.CONin, ifa.Read,
                  ifa.IncPC, ifa.Gra, ifa.Grb, ifa.BAout, ifa.alu_add, ifa.R_rd, ifa.Rin,
                  ifa.busy, ifa.done, ifa.illegal, ifa.step};
  assign obs_b = {ifb.PC_out, ifb.MDR_out, ifb.Zlo_out, ifb.R_out, ifb.C_out, ifb.MARin,
                  ifb.MDRin, ifb.IRin, ifb.PCin, ifb.Yin, ifb.Zlowin, ifb.CONin, ifb.Read,
                  ifb.IncPC, ifb.Gra, ifb.Grb, ifb.BAout, ifb.alu_add, ifb.R_rd, ifb.Rin,
                  ifb.busy, ifb.done, ifb.illegal, ifb.step};

  stim_t stim_q[$];
  obs_t  exp_q[$];
  int    n_checks = 0;
  int    n_errors = 0;

  // Expected strobes for T-step t of an instruction class, straight from the step table.
  function automatic obs_t t_obs(input int t, input int cls, input bit first);
    obs_t o;
    o = '0;
    o.busy = 1'b1;
    o.step = 3'(t);
    case (t)
      0: begin o.PC_out = 1; o.MARin = 1; o.Zlowin = 1; o.IncPC = first; end
      1: begin o.Zlo_out = 1; o.PCin = 1; o.Read = 1; o.MDRin = 1; end
      2: begin o.MDR_out = 1; o.IRin = 1; end
      3: begin
        if (cls == ClsJal) begin
          o.PC_out = 1; o.Rin = 1; o.R_rd = 16'h8000;
        end else if (cls == ClsJr) begin
          o.Gra = 1; o.R_out = 1; o.PCin = 1;
        end else begin
          o.Gra = 1; o.R_out = 1; o.CONin = 1;
        end
      end
      4: begin
        if (cls == ClsJal) begin o.Gra = 1; o.R_out = 1; o.PCin = 1; end
        else begin o.PC_out = 1; o.Yin = 1; end
      end
      5: begin o.C_out = 1; o.alu_add = 1; o.Zlowin = 1; end
      6: begin o.Zlo_out = 1; o.PCin = 1; end
      default: o = '0;
    endcase
    return o;
  endfunction

  function automatic stim_t mk_stim(input bit st, input bit h, input bit c, input bit cf,
                                    input logic [4:0] op);
    stim_t s;
    s.start = st; s.halt_req = h; s.clr = c; s.con_ff = cf; s.op = op; s.chk = 1'b1;
    return s;
  endfunction

  task automatic push_cyc(input stim_t s, input obs_t e);
    stim_q.push_back(s);
    exp_q.push_back(e);
  endtask

  task automatic push_idle(input int n, input bit st, input bit c, input bit ill, input bit chk);
    stim_t s;
    obs_t  e;
    for (int i = 0; i < n; i++) begin
      s = mk_stim(st, 1'b0, c, 1'b0, 5'b0);
      s.chk = chk;
      e = '0;
      e.illegal = ill;
      push_cyc(s, e);
    end
  endtask

  task automatic push_start(input logic [4:0] op, input bit cf);
    push_cyc(mk_stim(1'b1, 1'b0, 1'b0, cf, op), '0);
  endtask

  task automatic push_steps(input int cls, input bit cf, input logic [4:0] op, input int t_lo,
                            input int t_hi, input int halt_rel);
    int idx;
    idx = 0;
    for (int t = t_lo; t <= t_hi; t++) begin
      for (int c = 0; c < 2; c++) begin
        push_cyc(mk_stim(1'b0, idx == halt_rel, 1'b0, cf, op), t_obs(t, cls, c == 0));
        idx++;
      end
    end
  endtask

  task automatic push_body(input int cls, input bit cf, input logic [4:0] op, input int halt_rel,
                           input bit start_at_done);
    int   last_t;
    obs_t e;
    last_t = (cls == ClsJr) ? 3 : (cls == ClsJal) ? 4 : (cf ? 6 : 5);
    push_steps(cls, cf, op, 0, last_t, halt_rel);
    e = '0;
    e.done = 1'b1;
    push_cyc(mk_stim(start_at_done, 1'b0, 1'b0, cf, op), e);
  endtask

  task automatic tick(input bit sel, output obs_t o, output obs_t e, output bit chk);
    stim_t s;
    s = stim_q.pop_front();
    e = exp_q.pop_front();
    @(posedge clk);
    #1;
    start     = s.start;
    halt_req  = s.halt_req;
    clr       = s.clr;
    con_ff    = s.con_ff;
    ir_opcode = s.op;
    @(negedge clk);
    o   = sel ? obs_b : obs_a;
    chk = s.chk;
  endtask

  task automatic test_reset();
    obs_t o, e;
    bit   chk;
    int   cyc;
    push_idle(2, 1'b0, 1'b1, 1'b0, 1'b0);
    push_idle(3, 1'b0, 1'b0, 1'b0, 1'b1);
    cyc = 0;
    while (stim_q.size() > 0) begin
      tick(1'b0, o, e, chk);
      if (chk) begin
        n_checks++;
        if (o !== e) begin
          n_errors++;
          $display("FAIL reset cycle %0d: got %h required %h", cyc, o, e);
        end
      end
      cyc++;
    end
  endtask

  task automatic test_jr();
    obs_t o, e;
    bit   chk;
    int   cyc;
    push_start(OpJr, 1'b0);
    push_body(ClsJr, 1'b0, OpJr, -1, 1'b0);
    push_idle(2, 1'b0, 1'b0, 1'b0, 1'b1);
    cyc = 0;
    while (stim_q.size() > 0) begin
      tick(1'b0, o, e, chk);
      if (chk) begin
        n_checks++;
        if (o !== e) begin
          n_errors++;
          $display("FAIL jr cycle %0d: got %h required %h", cyc, o, e);
        end
      end
      cyc++;
    end
  endtask

  task automatic test_jal();
    obs_t o, e;
    bit   chk;
    int   cyc;
    push_start(OpJal, 1'b0);
    push_body(ClsJal, 1'b0, OpJal, -1, 1'b0);
    push_idle(2, 1'b0, 1'b0, 1'b0, 1'b1);
    cyc = 0;
    while (stim_q.size() > 0) begin
      tick(1'b0, o, e, chk);
      if (chk) begin
        n_checks++;
        if (o !== e) begin
          n_errors++;
          $display("FAIL jal cycle %0d: got %h required %h", cyc, o, e);
        end
      end
      cyc++;
    end
  endtask

  task automatic test_br();
    obs_t o, e;
    bit   chk;
    int   cyc;
    push_start(OpBr, 1'b1);
    push_body(ClsBr, 1'b1, OpBr, -1, 1'b0);
    push_idle(1, 1'b0, 1'b0, 1'b0, 1'b1);
    push_start(OpBr, 1'b0);
    push_body(ClsBr, 1'b0, OpBr, -1, 1'b0);
    push_idle(2, 1'b0, 1'b0, 1'b0, 1'b1);
    cyc = 0;
    while (stim_q.size() > 0) begin
      tick(1'b0, o, e, chk);
      if (chk) begin
        n_checks++;
        if (o !== e) begin
          n_errors++;
          $display("FAIL br cycle %0d: got %h required %h", cyc, o, e);
        end
      end
      cyc++;
    end
  endtask

  task automatic test_illegal();
    obs_t o, e;
    bit   chk;
    int   cyc;
    push_start(5'b00000, 1'b0);
    push_steps(ClsJr, 1'b0, 5'b00000, 0, 2, -1);
    push_idle(2, 1'b0, 1'b0, 1'b1, 1'b1);
    push_idle(1, 1'b1, 1'b0, 1'b1, 1'b1);
    push_idle(2, 1'b0, 1'b0, 1'b1, 1'b1);
    push_idle(1, 1'b0, 1'b1, 1'b1, 1'b1);
    push_idle(2, 1'b0, 1'b0, 1'b0, 1'b1);
    cyc = 0;
    while (stim_q.size() > 0) begin
      tick(1'b0, o, e, chk);
      if (chk) begin
        n_checks++;
        if (o !== e) begin
          n_errors++;
          $display("FAIL illegal cycle %0d: got %h required %h", cyc, o, e);
        end
      end
      cyc++;
    end
  endtask

  task automatic test_clr_abort();
    obs_t  o, e;
    bit    chk;
    int    cyc;
    stim_t s;
    push_start(OpJr, 1'b0);
    push_steps(ClsJr, 1'b0, OpJr, 0, 1, -1);
    s = stim_q[stim_q.size() - 1];
    s.clr = 1'b1;
    stim_q[stim_q.size() - 1] = s;
    push_idle(1, 1'b0, 1'b0, 1'b0, 1'b1);
    push_start(OpJr, 1'b0);
    push_body(ClsJr, 1'b0, OpJr, -1, 1'b0);
    push_idle(1, 1'b0, 1'b0, 1'b0, 1'b1);
    cyc = 0;
    while (stim_q.size() > 0) begin
      tick(1'b0, o, e, chk);
      if (chk) begin
        n_checks++;
        if (o !== e) begin
          n_errors++;
          $display("FAIL clr_abort cycle %0d: got %h required %h", cyc, o, e);
        end
      end
      cyc++;
    end
  endtask

  task automatic test_back_to_back();
    obs_t o, e;
    bit   chk;
    int   cyc;
    // start held through the done cycle is ignored there and only taken once back in idle.
    push_start(OpJr, 1'b0);
    push_body(ClsJr, 1'b0, OpJr, -1, 1'b1);
    push_start(OpJal, 1'b0);
    push_body(ClsJal, 1'b0, OpJal, -1, 1'b0);
    push_idle(1, 1'b0, 1'b0, 1'b0, 1'b1);
    cyc = 0;
    while (stim_q.size() > 0) begin
      tick(1'b0, o, e, chk);
      if (chk) begin
        n_checks++;
        if (o !== e) begin
          n_errors++;
          $display("FAIL back_to_back cycle %0d: got %h required %h", cyc, o, e);
        end
      end
      cyc++;
    end
  endtask

  task automatic test_continuous();
    obs_t o, e;
    bit   chk;
    int   cyc;
    push_idle(1, 1'b0, 1'b1, 1'b0, 1'b0);
    push_idle(1, 1'b0, 1'b0, 1'b0, 1'b1);
    push_start(OpJr, 1'b0);
    push_body(ClsJr, 1'b0, OpJr, -1, 1'b0);
    push_body(ClsJr, 1'b0, OpJr, 2, 1'b0);
    push_idle(3, 1'b0, 1'b0, 1'b0, 1'b1);
    cyc = -1;
    while (stim_q.size() > 0) begin
      tick(1'b1, o, e, chk);
      if (chk) begin
        n_checks++;
        if (o !== e) begin
          n_errors++;
          $display("FAIL continuous cycle %0d: got %h required %h", cyc, o, e);
        end
      end
      cyc++;
    end
  endtask

  initial begin
    test_reset();
    test_jr();
    test_jal();
    test_br();
    test_illegal();
    test_clr_abort();
    test_back_to_back();
    test_continuous();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
